// File: rtl/hazard_fwd_if.sv
// ID-stage request / hazard-response bundle between the decode stage (master)
// and the hazard/forwarding unit (slave).
interface hazard_fwd_if #(
    parameter int DEPTH = 3,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
);
    localparam int FW = $clog2(DEPTH + 1);

    logic            pipe_en;
    logic            id_valid;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic            id_rs1_used;
    logic            id_rs2_used;
    logic [RA_W-1:0] id_rd;
    logic            id_regwrite;
    logic            id_is_load;
    logic            flush;
    logic [FW-1:0]   fwd_sel1;
    logic [FW-1:0]   fwd_sel2;
    logic            stall_id;
    logic            ex_valid;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output pipe_en, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_regwrite, id_is_load, flush,
        input  fwd_sel1, fwd_sel2, stall_id, ex_valid, stall_cnt, flush_cnt
    );

    modport slave (
        input  pipe_en, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_regwrite, id_is_load, flush,
        output fwd_sel1, fwd_sel2, stall_id, ex_valid, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding controller: tracks in-flight destinations after ID, selects forwarding sources,
// raises load-use stalls. Define HAZARD_STATS_EN to build the stall/flush statistics counters.
module hazard_fwd_unit #(
    parameter int DEPTH    = 3,
    parameter int RA_W     = 5,
    parameter int LOAD_RDY = 2,
    parameter int CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    hazard_fwd_if.slave bus
);
    localparam int FW = $clog2(DEPTH + 1);

    if (DEPTH < 2) begin : g_bad_depth
        $error("hazard_fwd_unit: DEPTH must be >= 2");
    end
    if (LOAD_RDY < 1 || LOAD_RDY > DEPTH) begin : g_bad_load_rdy
        $error("hazard_fwd_unit: LOAD_RDY must be in 1..DEPTH");
    end

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic [RA_W-1:0] rd;
        logic            is_load;
    } entry_t;

    entry_t [DEPTH:1] ent_q;   // [1] = EX ... [DEPTH] = WB
    entry_t           issue;

    logic [DEPTH:1] hit1, hit2;
    logic [FW-1:0]  sel1, sel2;
    logic           unrdy1, unrdy2;
    logic           stall;

    for (genvar k = 1; k <= DEPTH; k++) begin : g_match
        logic prod;
        assign prod    = ent_q[k].valid & ent_q[k].regwrite & (ent_q[k].rd != '0);
        assign hit1[k] = prod & bus.id_rs1_used & (ent_q[k].rd == bus.id_rs1);
        assign hit2[k] = prod & bus.id_rs2_used & (ent_q[k].rd == bus.id_rs2);
    end

    // Walk oldest to youngest so the youngest match is the last one written.
    always_comb begin
        sel1   = '0;
        sel2   = '0;
        unrdy1 = 1'b0;
        unrdy2 = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (hit1[k]) begin
                sel1   = FW'(k);
                unrdy1 = ent_q[k].is_load && (k < LOAD_RDY);
            end
            if (hit2[k]) begin
                sel2   = FW'(k);
                unrdy2 = ent_q[k].is_load && (k < LOAD_RDY);
            end
        end
    end

    assign stall = bus.id_valid & ~bus.flush & (unrdy1 | unrdy2);

    always_comb begin
        issue          = '0;
        issue.valid    = bus.id_valid & ~stall & ~bus.flush;
        issue.regwrite = bus.id_regwrite;
        issue.rd       = bus.id_rd;
        issue.is_load  = bus.id_is_load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q <= '0;
        end else if (bus.pipe_en) begin
            ent_q <= {ent_q[DEPTH-1:1], issue};
        end
    end

    assign bus.fwd_sel1 = sel1;
    assign bus.fwd_sel2 = sel2;
    assign bus.stall_id = stall;
    assign bus.ex_valid = ent_q[1].valid;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating: a pegged counter means "at least this many".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (bus.pipe_en) begin
            if (stall && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (bus.flush && !(&flush_cnt_q))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule
